// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter giving two AXI-Stream writers packet-granular access to one memory write port,
// with per-channel base addressing and per-packet length/overrun reporting.
module mem_wr_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,

    input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axis_tstrb,
    input  logic                    s0_axis_tvalid,
    input  logic                    s0_axis_tlast,
    output logic                    s0_axis_tready,
    input  logic [ADDR_WIDTH-1:0]   s0_base_addr,

    input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axis_tstrb,
    input  logic                    s1_axis_tvalid,
    input  logic                    s1_axis_tlast,
    output logic                    s1_axis_tready,
    input  logic [ADDR_WIDTH-1:0]   s1_base_addr,

    output logic                    m_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   m_mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   m_mem_wr_tdata,
    output logic [DATA_WIDTH/8-1:0] m_mem_tstrb,
    output logic                    m_mem_tvalid,
    output logic                    m_mem_tlast,
    input  logic                    m_mem_tready,

    output logic [1:0]              grant,
    output logic                    pkt_done,
    output logic                    pkt_done_ch,
    output logic [ADDR_WIDTH:0]     pkt_len,
    output logic                    pkt_overrun
);

    // state   | meaning
    // IDLE    | no owner; arbitrate among valid requesters
    // GNT0/1  | channel 0/1 owns the memory port until its packet ends
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_BEAT = ADDR_WIDTH'(MAX_BEATS - 1);

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [ADDR_WIDTH-1:0] r_beat_cnt;
    logic                  r_pkt_done;
    logic                  r_pkt_done_ch;
    logic [ADDR_WIDTH:0]   r_pkt_len;
    logic                  r_pkt_overrun;

    logic w_src_last;
    logic w_beat;
    logic w_pick1;

    // Tie-break favours the channel that did not own the port last.
    assign w_pick1 = s1_axis_tvalid & (~s0_axis_tvalid | ~r_last_grant);

    always_comb begin
        m_mem_tvalid   = 1'b0;
        m_mem_wr_tdata = '0;
        m_mem_tstrb    = '0;
        m_mem_wr_addr  = '0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        w_src_last     = 1'b0;
        case (r_state)
            ST_GNT0: begin
                m_mem_tvalid   = s0_axis_tvalid;
                m_mem_wr_tdata = s0_axis_tdata;
                m_mem_tstrb    = s0_axis_tstrb;
                m_mem_wr_addr  = r_addr_cnt;
                s0_axis_tready = m_mem_tready;
                w_src_last     = s0_axis_tlast;
            end
            ST_GNT1: begin
                m_mem_tvalid   = s1_axis_tvalid;
                m_mem_wr_tdata = s1_axis_tdata;
                m_mem_tstrb    = s1_axis_tstrb;
                m_mem_wr_addr  = r_addr_cnt;
                s1_axis_tready = m_mem_tready;
                w_src_last     = s1_axis_tlast;
            end
            default: ;
        endcase
    end

    assign m_mem_wr_en = m_mem_tvalid;
    assign m_mem_tlast = (r_state != ST_IDLE) & (w_src_last | (r_beat_cnt == LP_LAST_BEAT));
    assign w_beat      = m_mem_tvalid & m_mem_tready;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_addr_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_pkt_done    <= 1'b0;
            r_pkt_done_ch <= 1'b0;
            r_pkt_len     <= '0;
            r_pkt_overrun <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s0_axis_tvalid | s1_axis_tvalid) begin
                        r_state    <= w_pick1 ? ST_GNT1 : ST_GNT0;
                        r_addr_cnt <= w_pick1 ? s1_base_addr : s0_base_addr;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (w_beat) begin
                        r_addr_cnt <= r_addr_cnt + 1'b1;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (m_mem_tlast) begin
                            r_state       <= ST_IDLE;
                            r_last_grant  <= (r_state == ST_GNT1);
                            r_pkt_done    <= 1'b1;
                            r_pkt_done_ch <= (r_state == ST_GNT1);
                            r_pkt_len     <= {1'b0, r_beat_cnt} + (ADDR_WIDTH+1)'(1);
                            r_pkt_overrun <= ~w_src_last;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant       = {r_state == ST_GNT1, r_state == ST_GNT0};
    assign pkt_done    = r_pkt_done;
    assign pkt_done_ch = r_pkt_done_ch;
    assign pkt_len     = r_pkt_len;
    assign pkt_overrun = r_pkt_overrun;

endmodule

// File: doc/mem_wr_arbiter.md
Name: mem_wr_arbiter

Overview:
- Round-robin arbiter sharing the memory block's single AXI-Stream write port between two stream requesters (ch0, ch1).
- Holds the grant for a whole packet, delimited by tlast or by a MAX_BEATS limit.
- Generates incrementing write addresses from a per-channel base address.
- Reports per-packet completion, length and overrun status.

Parameters:
ADDR_WIDTH, 12, memory address width; address counter width
DATA_WIDTH, 32, stream data width; tstrb is DATA_WIDTH/8
MAX_BEATS, 256, maximum beats per granted packet before forced termination (1..2^ADDR_WIDTH)

Ports:
axis_aclk  in  1  single clock, rising edge
axis_aresetn  in  1  asynchronous active-low reset
s0_axis_tdata  in  DATA_WIDTH  ch0 write data
s0_axis_tstrb  in  DATA_WIDTH/8  ch0 byte strobes
s0_axis_tvalid  in  1  ch0 valid
s0_axis_tlast  in  1  ch0 last beat of packet
s0_axis_tready  out  1  ch0 ready
s0_base_addr  in  ADDR_WIDTH  ch0 start address, sampled at grant
s1_axis_tdata / tstrb / tvalid / tlast / tready / s1_base_addr: same as ch0, for ch1
m_mem_wr_en  out  1  memory write enable
m_mem_wr_addr  out  ADDR_WIDTH  memory write address
m_mem_wr_tdata  out  DATA_WIDTH  memory write data
m_mem_tstrb  out  DATA_WIDTH/8  memory strobes
m_mem_tvalid  out  1  memory valid
m_mem_tlast  out  1  memory last beat
m_mem_tready  in  1  memory ready
grant  out  2  one-hot current grant (00 = idle)
pkt_done  out  1  one-cycle pulse at packet end
pkt_done_ch  out  1  channel of completed packet
pkt_len  out  ADDR_WIDTH+1  beats in completed packet
pkt_overrun  out  1  completed packet was terminated by MAX_BEATS

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: grant, tready, m_mem_*, pkt_done, pkt_done_ch, pkt_len, pkt_overrun.
- last_grant resets to 1, so ch0 wins the first contention.
- States: IDLE, GNT0, GNT1.
- IDLE → GNTx on the cycle any tvalid is high:
  - Only one requester valid: it wins.
  - Both valid: the channel != last_grant wins.
  - At the transition, addr_cnt <= sx_base_addr and beat_cnt <= 0.
  - Decision is registered: one cycle of latency from tvalid to grant. No transfers occur in IDLE.
- In GNTx, the granted channel is muxed combinationally to the memory port:
  - m_mem_tvalid = m_mem_wr_en = sx_axis_tvalid.
  - tdata and tstrb pass straight through.
  - m_mem_wr_addr = addr_cnt.
  - sx_axis_tready = m_mem_tready.
  - The non-granted channel's tready = 0.
- Beat = m_mem_tvalid & m_mem_tready. On each beat:
  - addr_cnt increments modulo 2^ADDR_WIDTH (0xFFF → 0x000).
  - beat_cnt increments.
  - No beat: address and count hold.
- m_mem_tlast = sx_axis_tlast | (beat_cnt == MAX_BEATS-1).
- End of packet = beat with m_mem_tlast high. On the next edge:
  - Return to IDLE; last_grant <= x.
  - pkt_done = 1 for one cycle; pkt_done_ch = x; pkt_len = beat_cnt+1.
  - pkt_overrun = 1 if sx_axis_tlast was low on that beat, else 0.
  - pkt_len, pkt_done_ch and pkt_overrun hold until the next pkt_done.
- Minimum one idle cycle between packets; back-to-back packets from the same channel re-arbitrate.
- Overrun: beats after a forced termination form a new packet. Its base is re-sampled from sx_base_addr at the new grant.
- tvalid deasserting mid-packet: grant is held and no timeout applies.
- Reset mid-packet: immediate abort to IDLE. No pkt_done, and the partial packet is not reported.

Test Plan:
1. Assert reset with tvalids high → all outputs 0, grant=00. Release → first grant one cycle later.
2. ch0 alone, base 0x001, beats 0x55,0x56,0x57, tlast on 3rd → wr_addr 0x001,0x002,0x003 with matching data. pkt_done pulse, pkt_done_ch=0, pkt_len=3, overrun=0. grant returns to 00.
3. Both channels continuously valid, 1-beat packets, bases 0x010/0x020 → grant sequence 01,10,01,10 with one idle cycle between. First winner is ch0.
4. ch1 3-beat packet with m_mem_tready low for 2 cycles after beat 1 → s1_axis_tready low, wr_addr held at base+1. All 3 words written once, in order. pkt_len=3.
5. ch0 base 0xFFE, 4 beats → wr_addr 0xFFE,0xFFF,0x000,0x001. pkt_len=4.
6. MAX_BEATS=4: ch1 sends 6 beats, tlast on 6th → beat 4 has m_mem_tlast=1, pkt_len=4, overrun=1. Regrant follows, then 2 beats from re-sampled base, pkt_len=2, overrun=0.
